// File: rtl/vmem_fill.sv
`default_nettype none
// ============================================================================
//  Module      : vmem_fill
//  Description : Memory-mapped rectangle-fill engine placed in front of the
//                video memory write port. It merges CPU single-pixel writes
//                with engine-generated fill writes onto one registered vmem
//                write port. The engine writes one pixel per cycle in
//                row-major order, clipped to the panel, and stalls whenever
//                the CPU writes.
//
//  Ports
//    clk_i              clock
//    rst_i              asynchronous active-high reset
//    cfg_we_i           register write strobe
//    cfg_addr_i[3:0]    register byte offset (0x0 ORIGIN, 0x4 SIZE,
//                       0x8 COLOR, 0xC CTRL)
//    cfg_wdata_i[31:0]  register write data
//    cfg_rdata_o[31:0]  read data for cfg_addr_i, one cycle later
//    cpu_vmem_we_i      CPU pixel write request
//    cpu_vmem_addr_i    CPU pixel address {y,x}
//    cpu_vmem_wdata_i   CPU pixel colour
//    vmem_we_o          registered write strobe to vmem
//    vmem_addr_o        registered {y[7:0],x[7:0]} to vmem
//    vmem_wdata_o       registered colour to vmem
//    busy_o             fill in progress
//    done_o             one-cycle pulse when a fill completes normally
//
//  Revision    : 1.0  initial release
// ============================================================================
module vmem_fill #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 240
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_we_i,
    input  logic [3:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    input  logic        cpu_vmem_we_i,
    input  logic [15:0] cpu_vmem_addr_i,
    input  logic [2:0]  cpu_vmem_wdata_i,
    output logic        vmem_we_o,
    output logic [15:0] vmem_addr_o,
    output logic [2:0]  vmem_wdata_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [3:0] c_ADDR_ORIGIN = 4'h0;
    localparam logic [3:0] c_ADDR_SIZE   = 4'h4;
    localparam logic [3:0] c_ADDR_COLOR  = 4'h8;
    localparam logic [3:0] c_ADDR_CTRL   = 4'hC;

    // Panel limits widened to 9 bits so that x0+w style sums never overflow.
    localparam logic [8:0] c_WIDTH9  = 9'(WIDTH);
    localparam logic [8:0] c_HEIGHT9 = 9'(HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Programmed registers (software view)
    logic [15:0] r_origin;
    logic [15:0] r_size;
    logic [2:0]  r_color;

    // Copies latched at start; the running fill only ever looks at these
    logic [7:0]  r_lx0;
    logic [7:0]  r_ly0;
    logic [7:0]  r_lw;
    logic [7:0]  r_lh;
    logic [2:0]  r_lcolor;

    // Scan position and exclusive clipped end coordinates
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [8:0]  r_xe;
    logic [8:0]  r_ye;

    logic [15:0] r_count;
    logic        r_done_sticky;
    logic        r_done;

    logic        r_vmem_we;
    logic [15:0] r_vmem_addr;
    logic [2:0]  r_vmem_wdata;
    logic [31:0] r_rdata;

    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_abort;
    logic        w_busy;
    logic        w_empty;
    logic        w_pixel_fire;
    logic [8:0]  w_xsum;
    logic [8:0]  w_ysum;
    logic [8:0]  w_xe;
    logic [8:0]  w_ye;
    logic [8:0]  w_x_inc;
    logic [8:0]  w_y_inc;
    logic        w_x_more;
    logic        w_y_more;
    logic        w_last;
    logic        w_unused;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_ctrl_wr = cfg_we_i && (cfg_addr_i == c_ADDR_CTRL);
    assign w_start   = w_ctrl_wr && cfg_wdata_i[0];
    assign w_abort   = w_ctrl_wr && cfg_wdata_i[1];

    // Upper write-data bits have no register behind them.
    assign w_unused  = ^cfg_wdata_i[31:16];

    // ------------------------------------------------------------------
    // Clip arithmetic (used in SETUP) and scan-advance terms (used in RUN)
    // ------------------------------------------------------------------
    assign w_xsum  = {1'b0, r_lx0} + {1'b0, r_lw};
    assign w_ysum  = {1'b0, r_ly0} + {1'b0, r_lh};
    assign w_xe    = (w_xsum > c_WIDTH9)  ? c_WIDTH9  : w_xsum;
    assign w_ye    = (w_ysum > c_HEIGHT9) ? c_HEIGHT9 : w_ysum;

    // A rectangle starting off-panel or with a zero dimension has no pixels.
    assign w_empty = (r_lw == 8'd0) || (r_lh == 8'd0) ||
                     ({1'b0, r_lx0} >= c_WIDTH9) ||
                     ({1'b0, r_ly0} >= c_HEIGHT9);

    assign w_x_inc  = {1'b0, r_x} + 9'd1;
    assign w_y_inc  = {1'b0, r_y} + 9'd1;
    assign w_x_more = (w_x_inc < r_xe);
    assign w_y_more = (w_y_inc < r_ye);
    assign w_last   = !w_x_more && !w_y_more;

    // The engine only advances on cycles the CPU leaves the port free.
    assign w_pixel_fire = (r_state == S_RUN) && !cpu_vmem_we_i;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-derived outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Abort in the same write suppresses the start.
                if (w_start && !w_abort) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_busy = 1'b1;
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_empty) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_pixel_fire && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Busy stays up until the edge that raises done_o.
                w_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_origin <= 16'd0;
            r_size   <= 16'd0;
            r_color  <= 3'd0;
        end else if (cfg_we_i) begin
            case (cfg_addr_i)
                c_ADDR_ORIGIN: r_origin <= cfg_wdata_i[15:0];
                c_ADDR_SIZE:   r_size   <= cfg_wdata_i[15:0];
                c_ADDR_COLOR:  r_color  <= cfg_wdata_i[2:0];
                default:       ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fill datapath: latched parameters, scan position, count, status
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lx0         <= 8'd0;
            r_ly0         <= 8'd0;
            r_lw          <= 8'd0;
            r_lh          <= 8'd0;
            r_lcolor      <= 3'd0;
            r_x           <= 8'd0;
            r_y           <= 8'd0;
            r_xe          <= 9'd0;
            r_ye          <= 9'd0;
            r_count       <= 16'd0;
            r_done_sticky <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start && !w_abort) begin
                        r_lx0         <= r_origin[7:0];
                        r_ly0         <= r_origin[15:8];
                        r_lw          <= r_size[7:0];
                        r_lh          <= r_size[15:8];
                        r_lcolor      <= r_color;
                        r_count       <= 16'd0;
                        r_done_sticky <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_x  <= r_lx0;
                    r_y  <= r_ly0;
                    r_xe <= w_xe;
                    r_ye <= w_ye;
                end
                S_RUN: begin
                    if (w_pixel_fire) begin
                        r_count <= r_count + 16'd1;
                        if (w_x_more) begin
                            r_x <= w_x_inc[7:0];
                        end else if (w_y_more) begin
                            r_x <= r_lx0;
                            r_y <= w_y_inc[7:0];
                        end
                    end
                end
                S_DONE: begin
                    r_done        <= 1'b1;
                    r_done_sticky <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // vmem write port: CPU has priority, engine fills the gaps in RUN
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vmem_we    <= 1'b0;
            r_vmem_addr  <= 16'd0;
            r_vmem_wdata <= 3'd0;
        end else if (cpu_vmem_we_i) begin
            r_vmem_we    <= 1'b1;
            r_vmem_addr  <= cpu_vmem_addr_i;
            r_vmem_wdata <= cpu_vmem_wdata_i;
        end else if (w_pixel_fire) begin
            r_vmem_we    <= 1'b1;
            r_vmem_addr  <= {r_y, r_x};
            r_vmem_wdata <= r_lcolor;
        end else begin
            // Address/data hold their last value; only the strobe drops.
            r_vmem_we    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered read-back
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= 32'd0;
        end else begin
            case (cfg_addr_i)
                c_ADDR_ORIGIN: r_rdata <= {16'd0, r_origin};
                c_ADDR_SIZE:   r_rdata <= {16'd0, r_size};
                c_ADDR_COLOR:  r_rdata <= {29'd0, r_color};
                c_ADDR_CTRL:   r_rdata <= {r_count, 14'd0, r_done_sticky, w_busy};
                default:       r_rdata <= 32'd0;
            endcase
        end
    end

    assign cfg_rdata_o  = r_rdata;
    assign vmem_we_o    = r_vmem_we;
    assign vmem_addr_o  = r_vmem_addr;
    assign vmem_wdata_o = r_vmem_wdata;
    assign busy_o       = w_busy;
    assign done_o       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vmem_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vmem_fill
//  Description : Self-checking bench for vmem_fill. A reference model keeps
//                the fill as a queue of clipped pixel addresses built by
//                nested loops over the rectangle, and predicts the vmem
//                stream, done/busy and register read-back cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vmem_fill;

    localparam int WIDTH  = 240;
    localparam int HEIGHT = 240;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_we_i;
    logic [3:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic        cpu_vmem_we_i;
    logic [15:0] cpu_vmem_addr_i;
    logic [2:0]  cpu_vmem_wdata_i;
    logic        vmem_we_o;
    logic [15:0] vmem_addr_o;
    logic [2:0]  vmem_wdata_o;
    logic        busy_o;
    logic        done_o;

    vmem_fill #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cfg_we_i         (cfg_we_i),
        .cfg_addr_i       (cfg_addr_i),
        .cfg_wdata_i      (cfg_wdata_i),
        .cfg_rdata_o      (cfg_rdata_o),
        .cpu_vmem_we_i    (cpu_vmem_we_i),
        .cpu_vmem_addr_i  (cpu_vmem_addr_i),
        .cpu_vmem_wdata_i (cpu_vmem_wdata_i),
        .vmem_we_o        (vmem_we_o),
        .vmem_addr_o      (vmem_addr_o),
        .vmem_wdata_o     (vmem_wdata_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [15:0] m_org, m_size;
    logic [2:0]  m_color, m_lcolor;
    logic [15:0] pend[$];
    bit          m_active, m_setup, m_run, m_donenext, m_sticky;
    logic [15:0] m_count;
    // predictions for the outputs after the latest edge
    logic        e_we;
    logic [15:0] e_addr;
    logic [2:0]  e_data;
    logic        e_done;
    logic [31:0] e_rdata;

    task automatic model_reset();
        m_org = 0; m_size = 0; m_color = 0; m_lcolor = 0;
        pend.delete();
        m_active = 0; m_setup = 0; m_run = 0; m_donenext = 0; m_sticky = 0;
        m_count = 0;
        e_we = 0; e_addr = 0; e_data = 0; e_done = 0; e_rdata = 0;
    endtask

    // Rectangle -> list of on-panel addresses in row-major order
    task automatic build_pixels();
        int x0, y0, w, h;
        x0 = int'(m_org[7:0]);  y0 = int'(m_org[15:8]);
        w  = int'(m_size[7:0]); h  = int'(m_size[15:8]);
        pend.delete();
        for (int yy = y0; yy < y0 + h && yy < HEIGHT; yy++)
            for (int xx = x0; xx < x0 + w && xx < WIDTH; xx++)
                pend.push_back({8'(yy), 8'(xx)});
    endtask

    // Advance one clock edge and update the model from the inputs seen there
    task automatic tick();
        bit start, abort;
        @(posedge clk_i);
        case (cfg_addr_i)
            4'h0:    e_rdata = {16'd0, m_org};
            4'h4:    e_rdata = {16'd0, m_size};
            4'h8:    e_rdata = {29'd0, m_color};
            4'hC:    e_rdata = {m_count, 14'd0, m_sticky, m_active};
            default: e_rdata = 32'd0;
        endcase
        start  = cfg_we_i && cfg_addr_i == 4'hC && cfg_wdata_i[0];
        abort  = cfg_we_i && cfg_addr_i == 4'hC && cfg_wdata_i[1];
        e_done = 0;
        e_we   = cpu_vmem_we_i;
        if (cpu_vmem_we_i) begin
            e_addr = cpu_vmem_addr_i;
            e_data = cpu_vmem_wdata_i;
        end
        if (m_donenext) begin
            e_done = 1; m_sticky = 1; m_donenext = 0; m_active = 0;
        end else if (m_run) begin
            if (!cpu_vmem_we_i) begin
                e_we = 1; e_addr = pend.pop_front(); e_data = m_lcolor;
                m_count = m_count + 16'd1;
                if (pend.size() == 0) begin m_run = 0; m_donenext = 1; end
            end
            if (abort) begin
                m_run = 0; m_donenext = 0; m_active = 0; pend.delete();
            end
        end else if (m_setup) begin
            m_setup = 0;
            if (abort) begin m_active = 0; pend.delete(); end
            else if (pend.size() == 0) m_donenext = 1;
            else m_run = 1;
        end else if (!m_active && start && !abort) begin
            build_pixels();
            m_lcolor = m_color; m_active = 1; m_setup = 1;
            m_count = 0; m_sticky = 0;
        end
        if (cfg_we_i) begin
            case (cfg_addr_i)
                4'h0: m_org   = cfg_wdata_i[15:0];
                4'h4: m_size  = cfg_wdata_i[15:0];
                4'h8: m_color = cfg_wdata_i[2:0];
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
        cfg_we_i = 1; cfg_addr_i = a; cfg_wdata_i = d;
        tick();
        cfg_we_i = 0; cfg_wdata_i = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1; cfg_we_i = 0; cfg_addr_i = 0; cfg_wdata_i = 0;
        cpu_vmem_we_i = 0; cpu_vmem_addr_i = 0; cpu_vmem_wdata_i = 0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({vmem_we_o, vmem_addr_o, vmem_wdata_o, busy_o, done_o, cfg_rdata_o} !== 54'd0) begin
            failures++;
            $display("FAIL reset_outputs got we=%b addr=%h data=%h busy=%b done=%b rdata=%h want all 0",
                     vmem_we_o, vmem_addr_o, vmem_wdata_o, busy_o, done_o, cfg_rdata_o);
        end
        rst_i = 0;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] exp_a [6];
        exp_a = '{16'h0A05, 16'h0A06, 16'h0B05, 16'h0B06, 16'h0C05, 16'h0C06};
        cfg_wr(4'h0, 32'h0000_0A05);
        cfg_wr(4'h4, 32'hFFFF_0302);
        cfg_wr(4'h8, 32'h0000_0005);
        cfg_addr_i = 4'h4; tick();
        checks++;
        if (cfg_rdata_o !== 32'h0000_0302) begin
            failures++;
            $display("FAIL size_readback got %h want 00000302", cfg_rdata_o);
        end
        cfg_wr(4'hC, 32'h1);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++; $display("FAIL basic_busy_after_start got %b want 1", busy_o);
        end
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (vmem_we_o !== 1'b1 || vmem_addr_o !== exp_a[k] || vmem_wdata_o !== 3'd5 || done_o !== 1'b0) begin
                failures++;
                $display("FAIL basic_pixel%0d got we=%b addr=%h data=%0d done=%b want we=1 addr=%h data=5 done=0",
                         k, vmem_we_o, vmem_addr_o, vmem_wdata_o, done_o, exp_a[k]);
            end
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || vmem_we_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got done=%b busy=%b we=%b want done=1 busy=0 we=0", done_o, busy_o, vmem_we_o);
        end
        cfg_addr_i = 4'hC; tick();
        checks++;
        if (done_o !== 1'b0 || cfg_rdata_o !== 32'h0006_0002) begin
            failures++;
            $display("FAIL basic_ctrl got done=%b ctrl=%h want done=0 ctrl=00060002", done_o, cfg_rdata_o);
        end
    endtask

    task automatic test_clip();
        int writes = 0;
        cfg_wr(4'h0, 32'h0000_EFEE);
        cfg_wr(4'h4, 32'h0000_0A0A);
        cfg_wr(4'h8, 32'h0000_0002);
        cfg_wr(4'hC, 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vmem_we_o === 1'b1) writes++;
            checks++;
            if (vmem_we_o !== e_we || (e_we && (vmem_addr_o !== e_addr || vmem_wdata_o !== e_data)) ||
                done_o !== e_done || busy_o !== m_active) begin
                failures++;
                $display("FAIL clip_cycle%0d got we=%b addr=%h data=%0d done=%b busy=%b want we=%b addr=%h data=%0d done=%b busy=%b",
                         i, vmem_we_o, vmem_addr_o, vmem_wdata_o, done_o, busy_o, e_we, e_addr, e_data, e_done, m_active);
            end
        end
        checks++;
        if (writes != 2) begin
            failures++; $display("FAIL clip_write_count got %0d want 2", writes);
        end
        // Empty: x0 = WIDTH
        cfg_wr(4'h0, 32'h0000_00F0);
        cfg_wr(4'hC, 32'h1);
        tick();
        checks++;
        if (done_o !== 1'b0 || vmem_we_o !== 1'b0) begin
            failures++; $display("FAIL empty_e1 got done=%b we=%b want done=0 we=0", done_o, vmem_we_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || vmem_we_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL empty_e2 got done=%b we=%b busy=%b want done=1 we=0 busy=0", done_o, vmem_we_o, busy_o);
        end
    endtask

    task automatic test_contention();
        logic [15:0] exp_a [5];
        logic [2:0]  exp_d [5];
        exp_a = '{16'h0000, 16'h1234, 16'h0001, 16'h0002, 16'h0003};
        exp_d = '{3'd7, 3'd3, 3'd7, 3'd7, 3'd7};
        cfg_wr(4'h0, 32'h0);
        cfg_wr(4'h4, 32'h0000_0104);
        cfg_wr(4'h8, 32'h7);
        cfg_wr(4'hC, 32'h1);
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                cpu_vmem_we_i = 1; cpu_vmem_addr_i = 16'h1234; cpu_vmem_wdata_i = 3'd3;
            end
            tick();
            cpu_vmem_we_i = 0;
            checks++;
            if (vmem_we_o !== 1'b1 || vmem_addr_o !== exp_a[k] || vmem_wdata_o !== exp_d[k] || done_o !== 1'b0) begin
                failures++;
                $display("FAIL contention_w%0d got we=%b addr=%h data=%0d done=%b want we=1 addr=%h data=%0d done=0",
                         k, vmem_we_o, vmem_addr_o, vmem_wdata_o, done_o, exp_a[k], exp_d[k]);
            end
        end
        tick();
        checks++;
        if (done_o !== 1'b1) begin
            failures++; $display("FAIL contention_done got %b want 1", done_o);
        end
    endtask

    task automatic test_abort();
        bit bad = 0;
        cfg_wr(4'h0, 32'h0);
        cfg_wr(4'h4, 32'h0000_0A0A);
        cfg_wr(4'h8, 32'h1);
        cfg_wr(4'hC, 32'h1);
        repeat (4) tick();          // setup + pixels 0..2
        cfg_wr(4'hC, 32'h2);        // pixel 3 still lands on this edge
        checks++;
        if (busy_o !== 1'b0 || vmem_we_o !== 1'b1 || vmem_addr_o !== 16'h0003) begin
            failures++;
            $display("FAIL abort_edge got busy=%b we=%b addr=%h want busy=0 we=1 addr=0003", busy_o, vmem_we_o, vmem_addr_o);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (vmem_we_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL abort_quiet got activity after abort want none");
        end
        cfg_addr_i = 4'hC; tick();
        checks++;
        if (cfg_rdata_o !== 32'h0004_0000) begin
            failures++; $display("FAIL abort_ctrl got %h want 00040000", cfg_rdata_o);
        end
        cfg_wr(4'hC, 32'h3);        // start+abort together: no fill
        cfg_addr_i = 4'hC; tick();
        checks++;
        if (busy_o !== 1'b0 || cfg_rdata_o !== 32'h0004_0000) begin
            failures++;
            $display("FAIL start_abort got busy=%b ctrl=%h want busy=0 ctrl=00040000", busy_o, cfg_rdata_o);
        end
    endtask

    task automatic test_restart_midfill();
        cfg_wr(4'h0, 32'h0000_0101);
        cfg_wr(4'h4, 32'h0000_0203);
        cfg_wr(4'h8, 32'h4);
        for (int i = 0; i < 22; i++) begin
            cfg_we_i = 0; cfg_addr_i = 4'hC; cfg_wdata_i = 0;
            if (i == 0 || i == 3 || i == 12) begin cfg_we_i = 1; cfg_wdata_i = 32'h1; end
            if (i == 4) begin cfg_we_i = 1; cfg_addr_i = 4'h0; cfg_wdata_i = 32'h2020; end
            tick();
            checks++;
            if (vmem_we_o !== e_we || (e_we && (vmem_addr_o !== e_addr || vmem_wdata_o !== e_data)) ||
                done_o !== e_done || busy_o !== m_active) begin
                failures++;
                $display("FAIL restart_cycle%0d got we=%b addr=%h data=%0d done=%b busy=%b want we=%b addr=%h data=%0d done=%b busy=%b",
                         i, vmem_we_o, vmem_addr_o, vmem_wdata_o, done_o, busy_o, e_we, e_addr, e_data, e_done, m_active);
            end
            if (i == 7 || i == 14) begin
                checks++;
                if (vmem_we_o !== 1'b1 || vmem_addr_o !== ((i == 7) ? 16'h0203 : 16'h2020)) begin
                    failures++;
                    $display("FAIL restart_addr_e%0d got we=%b addr=%h want we=1 addr=%h",
                             i, vmem_we_o, vmem_addr_o, (i == 7) ? 16'h0203 : 16'h2020);
                end
            end
        end
        cfg_we_i = 0;
    endtask

    task automatic test_random();
        logic [3:0] rd_addrs [4];
        int errs = 0;
        rd_addrs = '{4'h0, 4'h4, 4'h8, 4'hC};
        for (int i = 0; i < 900; i++) begin
            cfg_we_i = 0; cfg_wdata_i = 0;
            cfg_addr_i = rd_addrs[$urandom_range(0, 3)];
            case (i % 75)
                1: begin cfg_we_i = 1; cfg_addr_i = 4'h0;
                          cfg_wdata_i = {$urandom_range(0, 1) ? 8'($urandom_range(225, 255)) : 8'($urandom_range(0, 100)),
                                         $urandom_range(0, 1) ? 8'($urandom_range(225, 255)) : 8'($urandom_range(0, 100))}; end
                2: begin cfg_we_i = 1; cfg_addr_i = 4'h4;
                          cfg_wdata_i = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 9))}; end
                3: begin cfg_we_i = 1; cfg_addr_i = 4'h8; cfg_wdata_i = $urandom; end
                4: begin cfg_we_i = 1; cfg_addr_i = 4'hC; cfg_wdata_i = 32'h1; end
                30: if ($urandom_range(0, 3) == 0) begin cfg_we_i = 1; cfg_addr_i = 4'hC; cfg_wdata_i = 32'h2; end
                40: begin cfg_we_i = 1; cfg_addr_i = 4'h0; cfg_wdata_i = $urandom; end
                default: ;
            endcase
            cpu_vmem_we_i    = ($urandom_range(0, 3) == 0);
            cpu_vmem_addr_i  = 16'($urandom);
            cpu_vmem_wdata_i = 3'($urandom);
            tick();
            checks++;
            if (vmem_we_o !== e_we || (e_we && (vmem_addr_o !== e_addr || vmem_wdata_o !== e_data)) ||
                done_o !== e_done || busy_o !== m_active || cfg_rdata_o !== e_rdata) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d got we=%b addr=%h data=%0d done=%b busy=%b rd=%h want we=%b addr=%h data=%0d done=%b busy=%b rd=%h",
                             i, vmem_we_o, vmem_addr_o, vmem_wdata_o, done_o, busy_o, cfg_rdata_o,
                             e_we, e_addr, e_data, e_done, m_active, e_rdata);
            end
        end
        cfg_we_i = 0; cpu_vmem_we_i = 0;
        repeat (80) tick();         // let any fill drain before the next test
    endtask

    task automatic test_async_reset();
        bit bad = 0;
        cfg_wr(4'h0, 32'h0000_0303);
        cfg_wr(4'h4, 32'h0000_0505);
        cfg_wr(4'h8, 32'h6);
        cfg_wr(4'hC, 32'h1);
        repeat (5) tick();
        #2 rst_i = 1;
        #1;
        checks++;
        if ({vmem_we_o, vmem_addr_o, vmem_wdata_o, busy_o, done_o, cfg_rdata_o} !== 54'd0) begin
            failures++;
            $display("FAIL async_reset got we=%b addr=%h data=%h busy=%b done=%b rdata=%h want all 0",
                     vmem_we_o, vmem_addr_o, vmem_wdata_o, busy_o, done_o, cfg_rdata_o);
        end
        @(posedge clk_i);
        #1 rst_i = 0;
        model_reset();
        for (int i = 0; i < 15; i++) begin
            cfg_addr_i = 4'h0;
            tick();
            if (vmem_we_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || cfg_rdata_o !== 32'd0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL async_reset_quiet got activity or nonzero origin after reset want none");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_contention();
        test_abort();
        test_restart_midfill();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
